// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared types and defaults for the PLL lock supervisor.
//   state_t      supervisor FSM states
//   DEF_*        default parameter values
//   timer_width  width of the shared state timer
// Optional feature macro used by the supervisor: PLL_SUP_DEGLITCH_EN.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL,
    ST_WAIT_LOCK,
    ST_STABILIZE,
    ST_RUN,
    ST_FAULT
  } state_t;

  localparam int unsigned DEF_PLL_RST_CYCLES  = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT    = 20000;
  localparam int unsigned DEF_STABLE_CYCLES   = 1024;
  localparam int unsigned DEF_MAX_RETRIES     = 8;
  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_CNT_W           = 8;
  localparam int unsigned DEF_DEGLITCH_CYCLES = 4;

  // Timer only ever holds terminal-count values (N-1), so $clog2 of the
  // largest count is enough; clamp to 1 bit for degenerate settings.
  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c,
                                              input int unsigned d);
    int unsigned m;
    int unsigned w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_bit.sv
// sync_bit: STAGES-deep single-bit synchronizer.
//   clk    destination clock
//   rst_n  asynchronous active-low reset (chain resets to 0)
//   d      asynchronous input
//   q      synchronized output
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: drives PLL reset, qualifies PLL lock, retries on
// lock timeout and publishes a registered READY level.
//   CLK         free-running board reference clock
//   RST_N       asynchronous active-low reset
//   PLL_LOCKED  PLL lock indicator, asynchronous to CLK
//   SOFT_RST    synchronous single-cycle restart request
//   PLL_RST     PLL reset, active high
//   READY       PLL clocks qualified stable
//   FAULT       lock retries exhausted
//   LOSS_CNT    saturating count of lock losses seen in RUN
// Macro PLL_SUP_DEGLITCH_EN: when defined, RUN only declares a loss after
// DEGLITCH_CYCLES consecutive low lock samples.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES,
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W          = DEF_CNT_W
`ifdef PLL_SUP_DEGLITCH_EN
  , parameter int unsigned DEGLITCH_CYCLES = DEF_DEGLITCH_CYCLES
`endif
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             PLL_LOCKED,
  input  logic             SOFT_RST,
  output logic             PLL_RST,
  output logic             READY,
  output logic             FAULT,
  output logic [CNT_W-1:0] LOSS_CNT
);

`ifdef PLL_SUP_DEGLITCH_EN
  localparam int unsigned TW = timer_width(LOCK_TIMEOUT, STABLE_CYCLES,
                                           PLL_RST_CYCLES, DEGLITCH_CYCLES);
  localparam logic [TW-1:0] T_DG = TW'(DEGLITCH_CYCLES - 1);
`else
  localparam int unsigned TW = timer_width(LOCK_TIMEOUT, STABLE_CYCLES,
                                           PLL_RST_CYCLES, 1);
`endif
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

  localparam logic [TW-1:0] T_RST  = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_STAB = TW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRIES);

  logic             lock_s;
  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             pll_rst_q, ready_q, fault_q;
  logic             loss_evt;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (PLL_LOCKED),
    .q     (lock_s)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    retry_d  = retry_q;
    loss_d   = loss_q;
    loss_evt = 1'b0;

    if (SOFT_RST) begin
      state_d = ST_RESET_PLL;
      timer_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RESET_PLL: begin
          if (timer_q == T_RST) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock is tested first so a coincident timeout never burns a retry.
          if (lock_s) begin
            state_d = ST_STABILIZE;
            timer_d = '0;
          end else if (timer_q == T_LOCK) begin
            timer_d = '0;
            retry_d = retry_q + 1'b1;
            state_d = (retry_d == R_MAX) ? ST_FAULT : ST_RESET_PLL;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_STABILIZE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q == T_STAB) begin
            state_d = ST_RUN;
            timer_d = '0;
            retry_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_RUN: begin
`ifdef PLL_SUP_DEGLITCH_EN
          // Timer doubles as the consecutive-low counter while in RUN.
          if (lock_s)                 timer_d  = '0;
          else if (timer_q == T_DG)   loss_evt = 1'b1;
          else                        timer_d  = timer_q + 1'b1;
`else
          loss_evt = !lock_s;
`endif
          if (loss_evt) begin
            state_d = ST_RESET_PLL;
            timer_d = '0;
            if (loss_q != '1) loss_d = loss_q + 1'b1;
          end
        end
        ST_FAULT: begin
        end
        default: begin
          state_d = ST_RESET_PLL;
          timer_d = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_RESET_PLL;
      timer_q   <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
      ready_q   <= (state_d == ST_RUN);
      fault_q   <= (state_d == ST_FAULT);
    end
  end

  assign PLL_RST  = pll_rst_q;
  assign READY    = ready_q;
  assign FAULT    = fault_q;
  assign LOSS_CNT = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed bench for pll_lock_supervisor with
// PLL_RST_CYCLES=4, LOCK_TIMEOUT=50, STABLE_CYCLES=16, MAX_RETRIES=3,
// SYNC_STAGES=2, CNT_W=8. Inputs change and outputs are sampled on the
// falling edge of CLK.
module tb_pll_lock_supervisor;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       PLL_LOCKED = 1'b0;
  logic       SOFT_RST = 1'b0;
  logic       PLL_RST;
  logic       READY;
  logic       FAULT;
  logic [7:0] LOSS_CNT;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          n;
  int          bad;
  int          exp_loss;

  always #5 CLK = ~CLK;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (50),
    .STABLE_CYCLES  (16),
    .MAX_RETRIES    (3),
    .SYNC_STAGES    (2),
    .CNT_W          (8)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .PLL_LOCKED (PLL_LOCKED),
    .SOFT_RST   (SOFT_RST),
    .PLL_RST    (PLL_RST),
    .READY      (READY),
    .FAULT      (FAULT),
    .LOSS_CNT   (LOSS_CNT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Number of consecutive falling-edge samples (current one included)
  // with PLL_RST at lvl; bounded.
  task automatic run_len(input logic lvl, output int cnt);
    cnt = 0;
    while (PLL_RST === lvl && cnt < 1000) begin
      cnt++;
      @(negedge CLK);
    end
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (READY !== 1'b1 && cnt < 500) begin
      @(negedge CLK);
      cnt++;
    end
  endtask

  // SOFT_RST pulse with lock low; returns the PLL_RST pulse length and
  // leaves the bench at the first WAIT_LOCK sample.
  task automatic restart(output int hi);
    PLL_LOCKED = 1'b0;
    SOFT_RST   = 1'b1;
    @(negedge CLK);
    SOFT_RST   = 1'b0;
    run_len(1'b1, hi);
  endtask

  task automatic lose_once();
    int c;
    PLL_LOCKED = 1'b0;
    repeat (6) @(negedge CLK);
    PLL_LOCKED = 1'b1;
    wait_ready(c);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_pll_rst", 32'(PLL_RST), 1);
    chk("rst_ready", 32'(READY), 0);
    chk("rst_fault", 32'(FAULT), 0);
    chk("rst_loss", 32'(LOSS_CNT), 0);

    // 1: first lock
    RST_N = 1'b1;
    run_len(1'b1, n);
    chk("t1_rst_len", n, 4);
    repeat (10) @(negedge CLK);
    PLL_LOCKED = 1'b1;
    wait_ready(n);
    chk("t1_ready_lat", n, 19);
    chk("t1_fault", 32'(FAULT), 0);
    chk("t1_pll_rst", 32'(PLL_RST), 0);

    // 3: one-cycle lock drop in RUN
    PLL_LOCKED = 1'b0;
    @(negedge CLK);
    chk("t3_ready_e1", 32'(READY), 1);
    PLL_LOCKED = 1'b1;
    @(negedge CLK);
    chk("t3_ready_e2", 32'(READY), 1);
    @(negedge CLK);
`ifdef PLL_SUP_DEGLITCH_EN
    chk("t3_ready_e3", 32'(READY), 1);
    chk("t3_loss", 32'(LOSS_CNT), 0);
    chk("t3_pll_rst", 32'(PLL_RST), 0);
    exp_loss = 0;
`else
    chk("t3_ready_e3", 32'(READY), 0);
    chk("t3_loss", 32'(LOSS_CNT), 1);
    run_len(1'b1, n);
    chk("t3_repulse_len", n, 4);
    exp_loss = 1;
`endif

    // 4: lock drop in STABILIZE at stable count 10
    restart(n);
    chk("t4_restart_len", n, 4);
    PLL_LOCKED = 1'b1;
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 11) PLL_LOCKED = 1'b0;
      @(negedge CLK);
      if (READY !== 1'b0 || PLL_RST !== 1'b0 || FAULT !== 1'b0) bad++;
    end
    chk("t4_quiet", bad, 0);
    PLL_LOCKED = 1'b1;
    wait_ready(n);
    chk("t4_relock_lat", n, 19);

    // 2: retries exhausted
    restart(n);
    chk("t2_pulse1", n, 4);
    run_len(1'b0, n); chk("t2_wait1", n, 50);
    run_len(1'b1, n); chk("t2_pulse2", n, 4);
    run_len(1'b0, n); chk("t2_wait2", n, 50);
    run_len(1'b1, n); chk("t2_pulse3", n, 4);
    run_len(1'b0, n); chk("t2_wait3", n, 50);
    chk("t2_fault", 32'(FAULT), 1);
    chk("t2_fault_ready", 32'(READY), 0);
    repeat (20) @(negedge CLK);
    chk("t2_fault_hold", 32'(FAULT), 1);
    chk("t2_fault_pll_rst", 32'(PLL_RST), 1);
    restart(n);
    chk("t2_soft_pulse", n, 4);
    chk("t2_fault_clr", 32'(FAULT), 0);

    // 5: LOSS_CNT saturation
    PLL_LOCKED = 1'b1;
    wait_ready(n);
    chk("t5_ready_lat", n, 19);
    lose_once();
    exp_loss = exp_loss + 1;
    chk("t5_loss_first", 32'(LOSS_CNT), exp_loss);
    while (exp_loss < 255) begin
      lose_once();
      exp_loss = exp_loss + 1;
    end
    chk("t5_loss_255", 32'(LOSS_CNT), 255);
    lose_once();
    chk("t5_loss_sat", 32'(LOSS_CNT), 255);
    chk("t5_ready", 32'(READY), 1);

    // 6a: RST_N mid-STABILIZE
    restart(n);
    PLL_LOCKED = 1'b1;
    repeat (10) @(negedge CLK);
    chk("t6_stab_ready", 32'(READY), 0);
    RST_N = 1'b0;
    #1;
    chk("t6_rst_pll_rst", 32'(PLL_RST), 1);
    chk("t6_rst_ready", 32'(READY), 0);
    chk("t6_rst_fault", 32'(FAULT), 0);
    chk("t6_rst_loss", 32'(LOSS_CNT), 0);
    PLL_LOCKED = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    // 6b: SOFT_RST coincident with lock timeout
    run_len(1'b1, n);
    chk("t6_rst_len", n, 4);
    repeat (49) @(negedge CLK);
    SOFT_RST = 1'b1;
    @(negedge CLK);
    SOFT_RST = 1'b0;
    chk("t6_soft_pll_rst", 32'(PLL_RST), 1);
    run_len(1'b1, n);
    chk("t6_soft_pulse", n, 4);
    for (int k = 0; k < 3; k++) begin
      run_len(1'b0, n);
      chk("t6_wait", n, 50);
      if (k < 2) begin
        run_len(1'b1, n);
        chk("t6_pulse", n, 4);
      end
    end
    chk("t6_fault", 32'(FAULT), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
